// File: rtl/stream_seq_checker.sv
// stream_seq_checker: valid/ready stream sink with programmable backpressure, sequence and protocol checking
// Ports: r_clk clock, r_rst_n async active-low reset, en_i enable, clr_i sync clear of stats/flag/captures,
//   mode_i ready pattern (0 always, 1 never, 2 periodic, 3 random), valid_i/data_i/ready_o stream handshake,
//   beat/err/proto_err/stall *_cnt_o saturating counters, err_o sticky error,
//   first_exp_o/first_got_o first sequence mismatch, state_o 0 IDLE / 1 SYNC / 2 CHECK.
module stream_seq_checker #(
    parameter int         DATA_WIDTH  = 10,
    parameter int         CNT_WIDTH   = 32,
    parameter int         READY_ON    = 3,
    parameter int         READY_OFF   = 2,
    parameter logic [7:0] RAND_THRESH = 8'd128
) (
    input  logic                  r_clk,
    input  logic                  r_rst_n,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [1:0]            mode_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic [CNT_WIDTH-1:0]  beat_cnt_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic [CNT_WIDTH-1:0]  proto_err_cnt_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] first_exp_o,
    output logic [DATA_WIDTH-1:0] first_got_o,
    output logic [1:0]            state_o
);
    localparam logic [1:0] IDLE = 2'd0, SYNC = 2'd1, CHECK = 2'd2;
    localparam int PW = $clog2(READY_ON + READY_OFF);
    logic [1:0] state, state_n, mode_q;
    logic [DATA_WIDTH-1:0] exp_q, prev_data;
    logic [PW-1:0] phase;
    logic [15:0] lfsr;
    logic prev_pend, accept, active, seq_err, proto_err, stall, pat;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic inc);
        return (inc && !(&c)) ? c + CNT_WIDTH'(1) : c;
    endfunction

    assign accept    = valid_i && ready_o;
    assign active    = en_i && state != IDLE;
    assign seq_err   = accept && state == CHECK && data_i != exp_q;
    // a beat left pending last cycle must be presented again, unchanged
    assign proto_err = en_i && prev_pend && (!valid_i || data_i != prev_data);
    assign stall     = en_i && valid_i && !ready_o;
    assign state_o   = state;

    always_comb begin
        pat = mode_i == 2'd0 ? 1'b1 : mode_i == 2'd1 ? 1'b0 :
              mode_i == 2'd2 ? phase < PW'(READY_ON) : lfsr[7:0] < RAND_THRESH;
        state_n = !en_i ? IDLE : state == IDLE ? SYNC : (state == SYNC && !accept) ? SYNC : CHECK;
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            state           <= IDLE;
            ready_o         <= 1'b0;
            exp_q           <= '0;
            phase           <= '0;
            lfsr            <= 16'hACE1;
            mode_q          <= 2'd0;
            prev_pend       <= 1'b0;
            prev_data       <= '0;
            beat_cnt_o      <= '0;
            err_cnt_o       <= '0;
            proto_err_cnt_o <= '0;
            stall_cnt_o     <= '0;
            err_o           <= 1'b0;
            first_exp_o     <= '0;
            first_got_o     <= '0;
        end else begin
            state   <= state_n;
            ready_o <= active && pat;
            mode_q  <= mode_i;
            // on a match data_i equals exp_q, so data_i + 1 covers both advance and resync
            if (accept) exp_q <= data_i + 1'b1;
            if (!en_i || mode_i != mode_q) phase <= '0;
            else if (active) phase <= phase == PW'(READY_ON + READY_OFF - 1) ? '0 : phase + 1'b1;
            if (active) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            prev_pend <= en_i && valid_i && !ready_o;
            if (en_i) prev_data <= data_i;
            if (clr_i) begin
                beat_cnt_o      <= '0;
                err_cnt_o       <= '0;
                proto_err_cnt_o <= '0;
                stall_cnt_o     <= '0;
                err_o           <= 1'b0;
                first_exp_o     <= '0;
                first_got_o     <= '0;
            end else begin
                beat_cnt_o      <= sat_inc(beat_cnt_o, accept);
                err_cnt_o       <= sat_inc(err_cnt_o, seq_err);
                proto_err_cnt_o <= sat_inc(proto_err_cnt_o, proto_err);
                stall_cnt_o     <= sat_inc(stall_cnt_o, stall);
                err_o           <= err_o || seq_err || proto_err;
                if (seq_err && !err_o) begin
                    first_exp_o <= exp_q;
                    first_got_o <= data_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_seq_checker.sv
// tb_stream_seq_checker: randomized self-checking bench for stream_seq_checker against a behavioural model
module tb_stream_seq_checker;
    localparam int DW = 10, CW = 32, ON = 3, OFF = 2;
    localparam logic [7:0] THR = 8'd128;
    localparam longint CMAX = 64'hFFFF_FFFF;
    typedef logic [8:0][31:0] vec_t;

    logic r_clk = 0, r_rst_n = 0, en_i = 0, clr_i = 0, valid_i = 0;
    logic [1:0] mode_i = 0;
    logic [DW-1:0] data_i = 0;
    logic ready_o, err_o;
    logic [CW-1:0] beat_cnt_o, err_cnt_o, proto_err_cnt_o, stall_cnt_o;
    logic [DW-1:0] first_exp_o, first_got_o;
    logic [1:0] state_o;
    int n_vec = 0, n_bad = 0;
    string nm [9] = '{"state", "first_got", "first_exp", "err", "stall_cnt", "proto_cnt", "err_cnt", "beat_cnt", "ready"};

    // reference model state
    int m_state, m_phase;
    bit m_ready, m_pend, m_err;
    logic [DW-1:0] m_exp, m_pdata, m_fexp, m_fgot;
    logic [15:0] m_lfsr;
    logic [1:0] m_mode;
    longint m_beat, m_errs, m_proto, m_stall;

    stream_seq_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .READY_ON(ON), .READY_OFF(OFF), .RAND_THRESH(THR)) dut (
        .r_clk(r_clk), .r_rst_n(r_rst_n), .en_i(en_i), .clr_i(clr_i), .mode_i(mode_i),
        .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
        .beat_cnt_o(beat_cnt_o), .err_cnt_o(err_cnt_o), .proto_err_cnt_o(proto_err_cnt_o),
        .stall_cnt_o(stall_cnt_o), .err_o(err_o), .first_exp_o(first_exp_o),
        .first_got_o(first_got_o), .state_o(state_o)
    );

    always #5 r_clk = ~r_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic longint bump(input longint c, input bit inc);
        return (inc && c < CMAX) ? c + 1 : c;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic void model_reset();
        m_state = 0; m_phase = 0; m_ready = 0; m_pend = 0; m_err = 0;
        m_exp = 0; m_pdata = 0; m_fexp = 0; m_fgot = 0;
        m_lfsr = 16'hACE1; m_mode = 0;
        m_beat = 0; m_errs = 0; m_proto = 0; m_stall = 0;
    endfunction

    // advance the model by one rising edge using the inputs currently driven
    task automatic model_edge();
        bit acc, act, bad_seq, bad_proto, want;
        acc = valid_i && m_ready;
        act = en_i && m_state != 0;
        bad_seq = acc && m_state == 2 && data_i != m_exp;
        bad_proto = en_i && m_pend && (!valid_i || data_i != m_pdata);
        case (mode_i)
            2'd0: want = 1;
            2'd1: want = 0;
            2'd2: want = m_phase < ON;
            default: want = m_lfsr[7:0] < THR;
        endcase
        if (clr_i) begin
            m_beat = 0; m_errs = 0; m_proto = 0; m_stall = 0; m_err = 0; m_fexp = 0; m_fgot = 0;
        end else begin
            m_beat = bump(m_beat, acc);
            m_errs = bump(m_errs, bad_seq);
            m_proto = bump(m_proto, bad_proto);
            m_stall = bump(m_stall, en_i && valid_i && !m_ready);
            if (bad_seq && !m_err) begin m_fexp = m_exp; m_fgot = data_i; end
            m_err = m_err || bad_seq || bad_proto;
        end
        if (acc) m_exp = DW'(data_i + 1);
        m_phase = (!en_i || mode_i != m_mode) ? 0 : act ? (m_phase + 1) % (ON + OFF) : m_phase;
        if (act) m_lfsr = lfsr_next(m_lfsr);
        m_mode = mode_i;
        m_pend = en_i && valid_i && !m_ready;
        if (en_i) m_pdata = data_i;
        m_state = !en_i ? 0 : m_state == 0 ? 1 : (m_state == 1 && !acc) ? 1 : 2;
        m_ready = act && want;
    endtask

    function automatic vec_t dut_vec();
        return {32'(ready_o), beat_cnt_o, err_cnt_o, proto_err_cnt_o, stall_cnt_o,
                32'(err_o), 32'(first_exp_o), 32'(first_got_o), 32'(state_o)};
    endfunction

    function automatic vec_t model_vec();
        return {32'(m_ready), m_beat[31:0], m_errs[31:0], m_proto[31:0], m_stall[31:0],
                32'(m_err), 32'(m_fexp), 32'(m_fgot), 32'(m_state)};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge r_clk);
        @(negedge r_clk);
    endtask

    task automatic do_reset();
        r_rst_n = 0; en_i = 0; clr_i = 0; valid_i = 0;
        model_reset();
        repeat (2) @(negedge r_clk);
        r_rst_n = 1;
    endtask

    task automatic clear();
        en_i = 0; valid_i = 0; clr_i = 1;
        tick();
        clr_i = 0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        bit acc;
        int g = 0;
        valid_i = 1; data_i = d;
        do begin acc = m_ready; tick(); g++; end while (!acc && g < 100);
        if (!acc) begin
            n_vec++; n_bad++;
            $display("FAIL send_timeout data=%0d not accepted within 100 cycles", d);
        end
    endtask

    task automatic test_reset();
        vec_t g;
        do_reset();
        g = dut_vec();
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (g[i] !== 32'd0) begin n_bad++; $display("FAIL reset_%s got=%0d want=0", nm[i], g[i]); end
        end
    endtask

    task automatic test_wrap();
        mode_i = 0; clear();
        en_i = 1; tick();
        n_vec++;
        if (state_o !== 2'd1 || ready_o !== 1'b0) begin
            n_bad++; $display("FAIL wrap_sync state=%0d ready=%0b want state=1 ready=0", state_o, ready_o);
        end
        tick();
        n_vec++;
        if (ready_o !== 1'b1) begin n_bad++; $display("FAIL wrap_ready got=%0b want=1", ready_o); end
        for (int i = 0; i < 1030; i++) send(DW'(i % 1024));
        valid_i = 0;
        n_vec++;
        if (beat_cnt_o !== 32'd1030) begin n_bad++; $display("FAIL wrap_beats got=%0d want=1030", beat_cnt_o); end
        n_vec++;
        if (err_cnt_o !== 32'd0 || err_o !== 1'b0) begin
            n_bad++; $display("FAIL wrap_errors err_cnt=%0d err=%0b want 0/0", err_cnt_o, err_o);
        end
        en_i = 0; tick(); tick();
        n_vec++;
        if (state_o !== 2'd0) begin n_bad++; $display("FAIL wrap_idle state=%0d want=0", state_o); end
    endtask

    task automatic test_seq_error();
        logic [DW-1:0] seq [5] = '{0, 1, 2, 7, 8};
        mode_i = 0; clear();
        n_vec++;
        if (beat_cnt_o !== 32'd0) begin n_bad++; $display("FAIL clear_beats got=%0d want=0", beat_cnt_o); end
        en_i = 1;
        for (int i = 0; i < 5; i++) send(seq[i]);
        valid_i = 0;
        n_vec++;
        if (err_cnt_o !== 32'd1) begin n_bad++; $display("FAIL seq_err_cnt got=%0d want=1", err_cnt_o); end
        n_vec++;
        if (first_exp_o !== 10'd3 || first_got_o !== 10'd7) begin
            n_bad++; $display("FAIL seq_capture exp=%0d got=%0d want 3/7", first_exp_o, first_got_o);
        end
        n_vec++;
        if (beat_cnt_o !== 32'd5 || err_o !== 1'b1) begin
            n_bad++; $display("FAIL seq_beats beats=%0d err=%0b want 5/1", beat_cnt_o, err_o);
        end
        en_i = 0; tick();
    endtask

    task automatic test_periodic();
        logic [4:0] pat = 5'b00111;
        logic [DW-1:0] d = 0;
        bit acc;
        mode_i = 2; clear();
        en_i = 1; tick(); tick();
        for (int k = 0; k < 20; k++) begin
            valid_i = 1; data_i = d;
            n_vec++;
            if (ready_o !== pat[k % 5]) begin
                n_bad++; $display("FAIL periodic_ready cycle=%0d got=%0b want=%0b", k, ready_o, pat[k % 5]);
            end
            acc = m_ready; tick();
            if (acc) d++;
        end
        n_vec++;
        if (beat_cnt_o !== 32'd12 || stall_cnt_o !== 32'd8) begin
            n_bad++; $display("FAIL periodic_counts beats=%0d stalls=%0d want 12/8", beat_cnt_o, stall_cnt_o);
        end
        en_i = 0; valid_i = 0; tick();
    endtask

    task automatic test_proto();
        mode_i = 1; clear();
        en_i = 1; tick(); tick();
        valid_i = 1; data_i = 5; tick();
        valid_i = 0; tick();
        valid_i = 1; data_i = 9; tick();
        data_i = 10; tick();
        en_i = 0; valid_i = 0; tick();
        n_vec++;
        if (proto_err_cnt_o !== 32'd2 || err_o !== 1'b1) begin
            n_bad++; $display("FAIL proto_cnt got=%0d err=%0b want 2/1", proto_err_cnt_o, err_o);
        end
        n_vec++;
        if (beat_cnt_o !== 32'd0 || stall_cnt_o !== 32'd3) begin
            n_bad++; $display("FAIL proto_beats beats=%0d stalls=%0d want 0/3", beat_cnt_o, stall_cnt_o);
        end
    endtask

    task automatic test_lfsr();
        logic [DW-1:0] d = 0;
        bit acc;
        mode_i = 3; do_reset();
        en_i = 1; valid_i = 1; data_i = d;
        for (int k = 0; k < 1000; k++) begin
            acc = m_ready; tick();
            if (acc) begin d++; data_i = d; end
        end
        n_vec++;
        if (beat_cnt_o !== m_beat[31:0] || m_beat == 0) begin
            n_bad++; $display("FAIL lfsr_beats got=%0d want=%0d", beat_cnt_o, m_beat);
        end
        n_vec++;
        if (err_cnt_o !== 32'd0 || stall_cnt_o !== m_stall[31:0]) begin
            n_bad++; $display("FAIL lfsr_err_stall err=%0d stalls=%0d want 0/%0d", err_cnt_o, stall_cnt_o, m_stall);
        end
        en_i = 0; valid_i = 0; tick();
    endtask

    task automatic test_reset_mid();
        vec_t g;
        logic [DW-1:0] d;
        mode_i = 0; clear();
        en_i = 1;
        for (int i = 0; i < 50; i++) send(DW'(i));
        data_i = 50;
        #2;
        r_rst_n = 0; en_i = 0; valid_i = 0;
        model_reset();
        #1;
        g = dut_vec();
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (g[i] !== 32'd0) begin n_bad++; $display("FAIL midreset_%s got=%0d want=0", nm[i], g[i]); end
        end
        @(negedge r_clk);
        r_rst_n = 1;
        en_i = 1;
        d = DW'($urandom_range(0, 1023));
        for (int i = 0; i < 3; i++) send(DW'(d + i));
        valid_i = 0;
        n_vec++;
        if (beat_cnt_o !== 32'd3 || err_cnt_o !== 32'd0 || err_o !== 1'b0 || state_o !== 2'd2) begin
            n_bad++; $display("FAIL midreset_resync beats=%0d err_cnt=%0d err=%0b state=%0d want 3/0/0/2",
                              beat_cnt_o, err_cnt_o, err_o, state_o);
        end
        en_i = 0; tick();
    endtask

    task automatic test_random(input int cycles);
        vec_t g, w;
        bit pend = 0, acc;
        logic [DW-1:0] nxt = 0;
        clear();
        for (int c = 0; c < cycles; c++) begin
            if (en_i) en_i = $urandom_range(0, 99) != 0;
            else en_i = $urandom_range(0, 4) == 0;
            clr_i = $urandom_range(0, 199) == 0;
            if ($urandom_range(0, 149) == 0) mode_i = 2'($urandom_range(0, 3));
            if (!pend || $urandom_range(0, 39) == 0) begin
                valid_i = $urandom_range(0, 9) < 7;
                data_i = $urandom_range(0, 19) == 0 ? DW'($urandom) : nxt;
            end
            acc = valid_i && m_ready;
            tick();
            if (acc) nxt = DW'(data_i + 1);
            pend = valid_i && !acc;
            g = dut_vec(); w = model_vec();
            for (int i = 0; i < 9; i++) begin
                n_vec++;
                if (g[i] !== w[i]) begin
                    n_bad++; $display("FAIL rand_%s cycle=%0d got=%0d want=%0d", nm[i], c, g[i], w[i]);
                end
            end
        end
        en_i = 0; valid_i = 0; clr_i = 0; tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_wrap();
        test_seq_error();
        test_periodic();
        test_proto();
        test_lfsr();
        test_reset_mid();
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
